hnf_txrsp: RTL and testbench

Transmit side of the HN-F CHI RSP channel: accepts response flits from the home-node pipeline into a small FIFO and launches them on the TXRSP link under CHI link-layer credit control. It sits beside the request receiver in the `shhl` top level and is its counterpart on the link: it consumes the L-credits the downstream receiver grants, rather than granting them. It runs a three-state link FSM and returns all held credits with `RespLCrdReturn` flits on link deactivation.

---
 rtl/hnf_txrsp_if.sv | 47 ++++
 rtl/hnf_txrsp.sv | 155 +++++++++++++++
 tb/tb_hnf_txrsp.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hnf_txrsp_if.sv
// HN-F TXRSP bundle: response input from the home-node pipeline plus the
// outgoing CHI RSP link (flit, valid, pending, L-credit grant).
interface hnf_txrsp_if;

    typedef struct packed {
        logic [3:0]  qos;
        logic [10:0] tgtid;
        logic [10:0] srcid;
        logic [11:0] txnid;
        logic [4:0]  opcode;
        logic [1:0]  resperr;
        logic [2:0]  resp;
        logic [2:0]  fwdstate;
        logic [11:0] dbid;
        logic [3:0]  pcrdtype;
        logic        tracetag;
    } rspflit_t;

    rspflit_t rsp_in_flit;
    logic     rsp_in_valid;
    logic     rsp_in_ready;
    rspflit_t txrspflit;
    logic     txrspflitv;
    logic     txrspflitpend;
    logic     txrsplcrdv;

    modport master (
        input  rsp_in_flit,
        input  rsp_in_valid,
        input  txrsplcrdv,
        output rsp_in_ready,
        output txrspflit,
        output txrspflitv,
        output txrspflitpend
    );

    modport slave (
        output rsp_in_flit,
        output rsp_in_valid,
        output txrsplcrdv,
        input  rsp_in_ready,
        input  txrspflit,
        input  txrspflitv,
        input  txrspflitpend
    );

endinterface

// File: rtl/hnf_txrsp.sv
// HN-F TXRSP: response FIFO launched onto the CHI RSP link under L-credit control.
// Optional HNF_TXRSP_PERF_EN adds sent-flit and credit-stall counters.
module hnf_txrsp #(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_CRD    = 15
) (
    input  logic                         clock,
    input  logic                         reset,
    hnf_txrsp_if.master                  bus,
    input  logic                         txrsp_link_en,
    output logic [$clog2(MAX_CRD+1)-1:0] txrsp_crd_cnt,
    output logic                         txrsp_stopped,
    output logic                         txrsp_crd_ovf
`ifdef HNF_TXRSP_PERF_EN
    ,
    output logic [15:0]                  txrsp_sent_cnt,
    output logic [15:0]                  txrsp_stall_cnt
`endif
);

    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int PW     = AW + 1;
    localparam int CW     = $clog2(MAX_CRD + 1);
    localparam int FLIT_W = 68;
    localparam logic [CW-1:0] CRD_MAX = CW'(MAX_CRD);

    // state    | meaning
    // ST_STOP  | link idle, credit grants ignored
    // ST_RUN   | FIFO flits launched while credits last
    // ST_DEACT | every held credit handed back as a RespLCrdReturn flit
    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DEACT = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [FLIT_W-1:0]   r_mem [FIFO_DEPTH];
    logic [PW-1:0]       r_wptr;
    logic [PW-1:0]       r_rptr;
    logic [CW-1:0]       r_crd;
    logic [CW-1:0]       w_crd_nxt;
    logic [FLIT_W-1:0]   r_flit;
    logic                r_flitv;
    logic                r_pend;
    logic                r_ovf;
    logic                w_ovf_set;
    logic                w_empty;
    logic                w_full;
    logic                w_send;
    logic                w_pop;
    logic                w_push;
    logic                w_crd_in;
    logic                w_pend_nxt;
    logic [PW-1:0]       w_fifo_cnt;
    logic [PW-1:0]       w_cnt_nxt;

    assign w_empty    = (r_wptr == r_rptr);
    assign w_full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_fifo_cnt = r_wptr - r_rptr;

    // A launch needs the pend announced last cycle plus a held credit.
    assign w_send   = r_pend && (r_crd != '0) &&
                      (((r_state == ST_RUN) && !w_empty) || (r_state == ST_DEACT));
    assign w_pop    = w_send && (r_state == ST_RUN);
    assign w_crd_in = bus.txrsplcrdv && (r_state != ST_STOP);

    // Ready also covers full-with-pop so the slot being vacated can be refilled.
    assign bus.rsp_in_ready = !w_full || w_pop;
    assign w_push           = bus.rsp_in_valid && bus.rsp_in_ready;
    assign w_cnt_nxt        = w_fifo_cnt + PW'(w_push) - PW'(w_pop);

    always_comb begin
        w_crd_nxt = r_crd;
        w_ovf_set = 1'b0;
        if (w_crd_in && !w_send) begin
            if (r_crd == CRD_MAX) begin
                w_ovf_set = 1'b1;
            end else begin
                w_crd_nxt = r_crd + CW'(1);
            end
        end else if (!w_crd_in && w_send) begin
            w_crd_nxt = r_crd - CW'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_STOP:  if (txrsp_link_en) w_state_nxt = ST_RUN;
            ST_RUN:   if (!txrsp_link_en) w_state_nxt = ST_DEACT;
            ST_DEACT: if ((r_crd == '0) && !r_flitv) w_state_nxt = ST_STOP;
            default:  w_state_nxt = ST_STOP;
        endcase
    end

    assign w_pend_nxt = (w_crd_nxt != '0) &&
                        (((w_state_nxt == ST_RUN) && (w_cnt_nxt != '0)) ||
                         (w_state_nxt == ST_DEACT));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_STOP;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_crd   <= '0;
            r_flit  <= '0;
            r_flitv <= 1'b0;
            r_pend  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_crd   <= w_crd_nxt;
            r_pend  <= w_pend_nxt;
            r_flitv <= w_send;
            if (w_ovf_set) r_ovf <= 1'b1;
            // Credit returns are all-zero flits, i.e. opcode RespLCrdReturn.
            if (w_send) r_flit <= w_pop ? r_mem[r_rptr[AW-1:0]] : '0;
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= bus.rsp_in_flit;
    end

    assign bus.txrspflit     = r_flit;
    assign bus.txrspflitv    = r_flitv;
    assign bus.txrspflitpend = r_pend;
    assign txrsp_crd_cnt     = r_crd;
    assign txrsp_stopped     = (r_state == ST_STOP);
    assign txrsp_crd_ovf     = r_ovf;

`ifdef HNF_TXRSP_PERF_EN
    logic [15:0] r_sent_cnt;
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sent_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_pop) r_sent_cnt <= r_sent_cnt + 16'd1;
            if ((r_state == ST_RUN) && !w_empty && (r_crd == '0))
                r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign txrsp_sent_cnt  = r_sent_cnt;
    assign txrsp_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_hnf_txrsp.sv
// Directed bench for hnf_txrsp: scoreboard of expected flits checked as they
// leave the link; optional perf counters checked when HNF_TXRSP_PERF_EN is set.
module tb_hnf_txrsp;

    localparam int FLIT_W = 68;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       txrsp_link_en = 1'b0;
    logic [3:0] txrsp_crd_cnt;
    logic       txrsp_stopped;
    logic       txrsp_crd_ovf;
`ifdef HNF_TXRSP_PERF_EN
    logic [15:0] sent_cnt;
    logic [15:0] stall_cnt;
`endif

    hnf_txrsp_if bus();

    hnf_txrsp #(.FIFO_DEPTH(4), .MAX_CRD(15)) u_dut (
        .clock         (clock),
        .reset         (reset),
        .bus           (bus),
        .txrsp_link_en (txrsp_link_en),
        .txrsp_crd_cnt (txrsp_crd_cnt),
        .txrsp_stopped (txrsp_stopped),
        .txrsp_crd_ovf (txrsp_crd_ovf)
`ifdef HNF_TXRSP_PERF_EN
        ,
        .txrsp_sent_cnt  (sent_cnt),
        .txrsp_stall_cnt (stall_cnt)
`endif
    );

    always #5 clock = ~clock;

    int                n_checks = 0;
    int                n_errors = 0;
    logic [FLIT_W-1:0] exp_q[$];
    int                exp_ret  = 0;
    int                n_flits  = 0;
    int                n_rets   = 0;
    logic              prev_pend = 1'b0;

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_flit(input string tag, input logic [FLIT_W-1:0] obs,
                            input logic [FLIT_W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FLIT_W-1:0] rnd_flit();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[FLIT_W-1:0];
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [FLIT_W-1:0] f);
        bus.rsp_in_valid = 1'b1;
        bus.rsp_in_flit  = f;
        exp_q.push_back(f);
        tick();
    endtask

    task automatic grant(input int n);
        bus.txrsplcrdv = 1'b1;
        repeat (n) tick();
        bus.txrsplcrdv = 1'b0;
    endtask

    // Asserts reset between clock edges, holds it two cycles.
    task automatic apply_reset();
        bus.rsp_in_valid = 1'b0;
        bus.txrsplcrdv   = 1'b0;
        txrsp_link_en    = 1'b0;
        #1;
        reset = 1'b0;
        exp_q.delete();
        exp_ret = 0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk_int({tag, "_flitv"},   int'(bus.txrspflitv), 0);
        chk_int({tag, "_pend"},    int'(bus.txrspflitpend), 0);
        chk_flit({tag, "_flit"},   bus.txrspflit, '0);
        chk_int({tag, "_crd"},     int'(txrsp_crd_cnt), 0);
        chk_int({tag, "_stopped"}, int'(txrsp_stopped), 1);
        chk_int({tag, "_ovf"},     int'(txrsp_crd_ovf), 0);
        chk_int({tag, "_ready"},   int'(bus.rsp_in_ready), 1);
    endtask

    // Output monitor: every flit must follow a pend and match the scoreboard.
    always @(negedge clock) begin
        if (!reset) begin
            prev_pend = 1'b0;
        end else begin
            if (bus.txrspflitv) begin
                chk_int("pend_before_v", int'(prev_pend), 1);
                if (exp_ret > 0) begin
                    chk_flit("ret_flit", bus.txrspflit, '0);
                    chk_int("ret_opcode", int'(bus.txrspflit.opcode), 0);
                    exp_ret--;
                    n_rets++;
                end else if (exp_q.size() > 0) begin
                    chk_flit("data_flit", bus.txrspflit, exp_q.pop_front());
                    n_flits++;
                end else begin
                    chk_int("unexpected_flit", int'(bus.txrspflitv), 0);
                end
            end
            prev_pend = bus.txrspflitpend;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int r0;
        bus.rsp_in_valid = 1'b0;
        bus.rsp_in_flit  = '0;
        bus.txrsplcrdv   = 1'b0;
        #1 reset = 1'b0;
        #2 check_reset_vals("por");
        tick();
        reset = 1'b1;

        // 3 credits, 3 back-to-back pushes
        txrsp_link_en = 1'b1;
        tick();
        chk_int("t1_run", int'(txrsp_stopped), 0);
        grant(3);
        chk_int("t1_crd3", int'(txrsp_crd_cnt), 3);
        chk_int("t1_rdy0", int'(bus.rsp_in_ready), 1);
        push(rnd_flit());
        chk_int("t1_pend_c1", int'(bus.txrspflitpend), 1);
        chk_int("t1_v_c1", int'(bus.txrspflitv), 0);
        chk_int("t1_rdy1", int'(bus.rsp_in_ready), 1);
        push(rnd_flit());
        chk_int("t1_v_c2", int'(bus.txrspflitv), 1);
        chk_int("t1_rdy2", int'(bus.rsp_in_ready), 1);
        push(rnd_flit());
        chk_int("t1_v_c3", int'(bus.txrspflitv), 1);
        bus.rsp_in_valid = 1'b0;
        tick();
        chk_int("t1_v_c4", int'(bus.txrspflitv), 1);
        tick();
        chk_int("t1_v_c5", int'(bus.txrspflitv), 0);
        chk_int("t1_crd0", int'(txrsp_crd_cnt), 0);
        chk_int("t1_drain", exp_q.size(), 0);
        chk_int("t1_rdy_end", int'(bus.rsp_in_ready), 1);

        // Zero credits: FIFO fills, one grant releases exactly one flit
        apply_reset();
        txrsp_link_en = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk_int("t2_rdy_fill", int'(bus.rsp_in_ready), 1);
            push(rnd_flit());
        end
        bus.rsp_in_valid = 1'b0;
        chk_int("t2_rdy_full", int'(bus.rsp_in_ready), 0);
        n0 = n_flits;
        repeat (5) tick();
        chk_int("t2_no_send", n_flits, n0);
        chk_int("t2_still_full", int'(bus.rsp_in_ready), 0);
        bus.txrsplcrdv = 1'b1;
        tick();
        bus.txrsplcrdv = 1'b0;
        chk_int("t2_v_g1", int'(bus.txrspflitv), 0);
        chk_int("t2_pend_g1", int'(bus.txrspflitpend), 1);
        tick();
        chk_int("t2_v_g2", int'(bus.txrspflitv), 1);
        tick();
        chk_int("t2_v_g3", int'(bus.txrspflitv), 0);
        repeat (4) tick();
        chk_int("t2_one_flit", n_flits, n0 + 1);
        chk_int("t2_crd0", int'(txrsp_crd_cnt), 0);

        // Credit overflow at MAX_CRD, then grant coinciding with a send
        apply_reset();
        txrsp_link_en = 1'b1;
        tick();
        grant(15);
        chk_int("t3_crd15", int'(txrsp_crd_cnt), 15);
        chk_int("t3_ovf0", int'(txrsp_crd_ovf), 0);
        grant(1);
        chk_int("t3_crd_sat", int'(txrsp_crd_cnt), 15);
        chk_int("t3_ovf1", int'(txrsp_crd_ovf), 1);
        tick();
        chk_int("t3_ovf_sticky", int'(txrsp_crd_ovf), 1);
        apply_reset();
        chk_int("t3_ovf_rst", int'(txrsp_crd_ovf), 0);
        txrsp_link_en = 1'b1;
        tick();
        grant(15);
        push(rnd_flit());
        bus.rsp_in_valid = 1'b0;
        chk_int("t3_pend", int'(bus.txrspflitpend), 1);
        bus.txrsplcrdv = 1'b1;
        tick();
        bus.txrsplcrdv = 1'b0;
        chk_int("t3_v_send", int'(bus.txrspflitv), 1);
        chk_int("t3_crd_keep", int'(txrsp_crd_cnt), 15);
        chk_int("t3_no_ovf", int'(txrsp_crd_ovf), 0);

        // Deactivation returns credits, FIFO contents survive
        apply_reset();
        txrsp_link_en = 1'b1;
        tick();
        push(rnd_flit());
        push(rnd_flit());
        bus.rsp_in_valid = 1'b0;
        n0 = n_flits;
        r0 = n_rets;
        repeat (2) tick();
        exp_ret = 4;
        txrsp_link_en = 1'b0;
        bus.txrsplcrdv = 1'b1;
        tick();
        chk_int("t4_deact", int'(txrsp_stopped), 0);
        repeat (3) tick();
        bus.txrsplcrdv = 1'b0;
        for (int i = 0; i < 30 && !txrsp_stopped; i++) tick();
        chk_int("t4_stop", int'(txrsp_stopped), 1);
        chk_int("t4_rets", n_rets, r0 + 4);
        chk_int("t4_no_data", n_flits, n0);
        chk_int("t4_crd0", int'(txrsp_crd_cnt), 0);
        chk_int("t4_q_held", exp_q.size(), 2);
        txrsp_link_en = 1'b1;
        tick();
        grant(2);
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
        chk_int("t4_resumed", exp_q.size(), 0);
        chk_int("t4_data", n_flits, n0 + 2);

        // Async reset mid-burst
        apply_reset();
        txrsp_link_en = 1'b1;
        tick();
        grant(3);
        push(rnd_flit());
        push(rnd_flit());
        push(rnd_flit());
        chk_int("t5_burst", int'(bus.txrspflitv), 1);
        bus.rsp_in_valid = 1'b0;
        bus.txrsplcrdv   = 1'b0;
        txrsp_link_en    = 1'b0;
        #1;
        reset = 1'b0;
        exp_q.delete();
        exp_ret = 0;
        #1;
        check_reset_vals("async");
        tick();
        tick();
        reset = 1'b1;
        tick();

`ifdef HNF_TXRSP_PERF_EN
        // 10 stall cycles followed by 3 sends
        apply_reset();
        txrsp_link_en = 1'b1;
        tick();
        push(rnd_flit());
        push(rnd_flit());
        push(rnd_flit());
        bus.rsp_in_valid = 1'b0;
        repeat (7) tick();
        grant(3);
        repeat (4) tick();
        chk_int("perf_stall", int'(stall_cnt), 10);
        chk_int("perf_sent", int'(sent_cnt), 3);
        chk_int("perf_drain", exp_q.size(), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
